// File: rtl/mux_n_pkg.sv
// mux_n_pkg: shared mode encodings and sequencer widths for the mux_n_pipe unit
package mux_n_pkg;
    typedef enum logic [1:0] {
        MODE_DATA_SEL   = 2'd0,
        MODE_STATIC_SEL = 2'd1,
        MODE_RR         = 2'd2,
        MODE_HOLD       = 2'd3
    } mode_e;
    localparam int RR_PERIOD_W = 16;
endpackage

// File: rtl/mux_n_pipe_if.sv
// mux_n_pipe_if: configuration, data and status signals of the mux_n_pipe unit
interface mux_n_pipe_if
    import mux_n_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_IN = 8,
    parameter int SEL_W = N_IN > 2 ? $clog2(N_IN) : 1
);
    logic                    running;
    logic                    run;
    logic [N_IN*DATA_W-1:0]  in_data;
    logic [DATA_W-1:0]       sel_in;
    mode_e                   mode;
    logic [SEL_W-1:0]        static_sel;
    logic [RR_PERIOD_W-1:0]  rr_period;
    logic [DATA_W-1:0]       out0;
    logic                    rr_wrap;
    modport master (
        output running, run, in_data, sel_in, mode, static_sel, rr_period,
        input  out0, rr_wrap
    );
    modport slave (
        input  running, run, in_data, sel_in, mode, static_sel, rr_period,
        output out0, rr_wrap
    );
endinterface

// File: rtl/mux_n_rr_ctrl.sv
// mux_n_rr_ctrl: round-robin index sequencer with programmable dwell and wrap pulse
module mux_n_rr_ctrl
    import mux_n_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run,
    input  logic                               running,
    input  logic                               enable,
    input  logic [RR_PERIOD_W-1:0]             rr_period,
    output logic [(N_IN > 2 ? $clog2(N_IN) : 1)-1:0] rr_idx,
    output logic                               rr_wrap
);
    localparam int SEL_W = N_IN > 2 ? $clog2(N_IN) : 1;
    logic [RR_PERIOD_W-1:0] dwell_d, dwell_q, last;
    logic [SEL_W-1:0]       idx_d, idx_q;
    logic                   wrap_d, wrap_q, adv, step;
    // dwell countdown and index advance; a run pulse restarts both and beats any advance
    always_comb begin
        last    = rr_period == '0 ? '0 : rr_period - 1'b1;
        adv     = running && enable && !run;
        step    = adv && dwell_q == last;
        wrap_d  = step && idx_q == SEL_W'(N_IN - 1);
        dwell_d = run || step ? '0 : adv ? dwell_q + 1'b1 : dwell_q;
        idx_d   = run || wrap_d ? '0 : step ? idx_q + 1'b1 : idx_q;
    end
    // sequencer state, cleared asynchronously
    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            dwell_q <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end
    assign rr_idx  = idx_q;
    assign rr_wrap = wrap_q;
endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way input select (data/static/round-robin) through a LATENCY-stage holdable pipeline
module mux_n_pipe
    import mux_n_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_IN = 8,
    parameter int LATENCY = 1
) (
    input logic         clk,
    input logic         rst,
    mux_n_pipe_if.slave bus
);
    localparam int SEL_W = N_IN > 2 ? $clog2(N_IN) : 1;
    localparam int N_WORDS = 1 << SEL_W;
    logic [SEL_W-1:0]  rr_idx, idx;
    logic [DATA_W-1:0] words [N_WORDS];
    logic [DATA_W-1:0] sel_word;
    logic              en;
    // indices past N_IN map to constant zero words so a stray selector never yields X
    for (genvar k = 0; k < N_WORDS; k++) begin : g_w
        if (k < N_IN) begin : g_in
            assign words[k] = bus.in_data[k*DATA_W +: DATA_W];
        end else begin : g_zero
            assign words[k] = '0;
        end
    end
    mux_n_rr_ctrl #(.N_IN(N_IN)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .run       (bus.run),
        .running   (bus.running),
        .enable    (bus.mode == MODE_RR),
        .rr_period (bus.rr_period),
        .rr_idx    (rr_idx),
        .rr_wrap   (bus.rr_wrap)
    );
    // pick the index source for this cycle and fetch the word; HOLD stalls every stage
    always_comb begin
        idx      = bus.mode == MODE_DATA_SEL   ? bus.sel_in[SEL_W-1:0] :
                   bus.mode == MODE_STATIC_SEL ? bus.static_sel : rr_idx;
        sel_word = words[idx];
        en       = bus.mode != MODE_HOLD;
    end
    for (genvar s = 0; s < LATENCY; s++) begin : g_st
        logic [DATA_W-1:0] stage_d, stage_q, prev;
        if (s == 0) begin : g_head
            assign prev = sel_word;
        end else begin : g_tail
            assign prev = g_st[s-1].stage_q;
        end
        // shift the previous stage in unless holding
        always_comb stage_d = en ? prev : stage_q;
        // stage register, cleared asynchronously
        always_ff @(posedge clk, posedge rst) begin
            if (rst) stage_q <= '0;
            else     stage_q <= stage_d;
        end
    end
    assign bus.out0 = g_st[LATENCY-1].stage_q;
endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

- Parametrised Versat functional unit.
- Selects one of N_IN data inputs per cycle and delivers it through a LATENCY-stage register pipeline.
- Selection source is chosen at run time: a data-driven selector input, a static configuration index, or an internal round-robin sequencer with a programmable dwell period.
- A hold mode freezes the pipeline.
- Placed in the Versat datapath wherever a multi-way or time-interleaved merge of streams is needed.

## Interface
Parameters:
- DATA_W, 32, width of every data input and output
- N_IN, 8, number of selectable inputs (2..64, need not be a power of two)
- LATENCY, 1, pipeline stages from sample to out0 (>= 1); reported to Versat as the unit latency
- SEL_W, derived ($clog2(N_IN), min 1), selector index width; not user-set

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- running  in  1  accelerator running phase
- run  in  1  single-cycle start pulse
- in_data  in  N_IN*DATA_W  flattened inputs; input k at bits [k*DATA_W +: DATA_W]
- sel_in  in  DATA_W  data-driven selector; only bits [SEL_W-1:0] used
- mode  in  2  config: 0 DATA_SEL, 1 STATIC_SEL, 2 ROUND_ROBIN, 3 HOLD
- static_sel  in  SEL_W  config index for STATIC_SEL
- rr_period  in  16  config: cycles spent on each input in ROUND_ROBIN; 0 treated as 1
- out0  out  DATA_W  selected data, LATENCY cycles after sampling
- rr_wrap  out  1  one-cycle pulse when round-robin index wraps N_IN-1 -> 0

## Operation
- Effective index idx:
  - DATA_SEL: sel_in[SEL_W-1:0]
  - STATIC_SEL: static_sel
  - ROUND_ROBIN: internal rr_idx
- idx >= N_IN selects the value 0, never X. This applies only to non-power-of-two N_IN.
- Stage 0 registers the selected word every cycle unless mode == HOLD. Stages 1..LATENCY-1 shift under the same enable.
- HOLD: all stages keep their value. Leaving HOLD resumes shifting on the next edge; nothing is lost or duplicated.
- The pipeline advances regardless of running, except in HOLD.
- Round-robin sequencer: 16-bit dwell counter dwell_cnt and rr_idx.
  - run pulse: rr_idx <= 0, dwell_cnt <= 0. run has priority over advance in the same cycle.
  - running && mode == ROUND_ROBIN && !run, with dwell_cnt == max(rr_period,1)-1: dwell_cnt <= 0, rr_idx <= (rr_idx == N_IN-1) ? 0 : rr_idx+1, rr_wrap pulses 1 in the cycle after the wrap edge.
  - Same condition, otherwise: dwell_cnt increments.
  - !running, or another mode: counters hold.
- Config inputs are static while running. A mode change mid-run takes effect on the next edge and does not reset the sequencer.

## Timing
- Reset values: every pipeline stage, out0, rr_idx, dwell_cnt and rr_wrap are 0.
- rst asserted mid-operation clears everything immediately, asynchronously. First valid sample is at the first edge after deassertion.
- Data/selector sampled at edge t appear on out0 after edge t+LATENCY-1, i.e. usable in cycle t+LATENCY. LATENCY=1 gives one registered stage.
- In ROUND_ROBIN, rr_idx at edge t chooses the word sampled at t. With rr_period=P, each input is sampled for exactly P consecutive running cycles.
- rr_wrap is registered: high for one cycle, coincident with rr_idx == 0 after the wrap.

## Structure
- Shared package mux_n_pkg: mode encodings (MODE_DATA_SEL, MODE_STATIC_SEL, MODE_RR, MODE_HOLD), RR_PERIOD_W = 16.
- Sub-module mux_n_rr_ctrl: dwell counter, rr_idx, rr_wrap. Inputs run, running, enable (mode == RR), rr_period. Parameter N_IN.
- Top contains the index mux, the out-of-range zeroing and the generate-loop pipeline of LATENCY stages.

## Test plan
- Reset: assert rst mid-stream with LATENCY=3 -> out0, rr_idx, rr_wrap = 0 immediately; after release, first new sample appears 3 cycles after its sample edge.
- DATA_SEL, N_IN=8, LATENCY=2, input k = 0x100+k, sel_in sweeps 0..7 -> out0 = 0x100..0x107, two cycles behind sel_in.
- N_IN=5, sel_in = 6 -> out0 = 0. static_sel = 4 in STATIC_SEL -> out0 = 0x104.
- ROUND_ROBIN, N_IN=4, rr_period=3, run pulse then running for 14 cycles -> indices 0,0,0,1,1,1,2,2,2,3,3,3,0,0; rr_wrap exactly once, aligned with the return to 0. Repeat with rr_period=0 -> index changes every cycle.
- run pulse mid-sequence at rr_idx=2 -> next sample uses index 0, dwell restarts at 0.
- HOLD for 5 cycles with inputs changing, LATENCY=3 -> out0 constant. On exit, the three pre-HOLD words emerge in order, followed by new samples.
